// File: rtl/runner_game_core_if.sv
// Runner engine interface: run permission, keys, random source, and the frame/score outputs.
// master drives the keys and RAND; slave is the engine core.
interface runner_game_core_if #(
    parameter int COLS    = 16,
    parameter int SCORE_W = 16
);
    logic                 ENABLE;
    logic                 JUMP_KEY;
    logic                 ABORT_KEY;
    logic [7:0]           RAND;
    logic [1:0]           STATE;
    logic [2*COLS-1:0]    LANE;
    logic                 AIR;
    logic [SCORE_W-1:0]   SCORE;
    logic [SCORE_W-1:0]   HISCORE;
    logic                 TICK;

    modport master (
        output ENABLE, JUMP_KEY, ABORT_KEY, RAND,
        input  STATE, LANE, AIR, SCORE, HISCORE, TICK
    );

    modport slave (
        input  ENABLE, JUMP_KEY, ABORT_KEY, RAND,
        output STATE, LANE, AIR, SCORE, HISCORE, TICK
    );
endinterface

// File: rtl/runner_game_core.sv
// Side-scrolling runner engine: game FSM, speed-up tick generator, jump timer, obstacle lane, score.
// Optional high-score register is built only when RUNNER_HISCORE_EN is defined.
module runner_game_core #(
    parameter int COLS          = 16,
    parameter int TICK_DIV      = 250000,
    parameter int TICK_MIN      = 62500,
    parameter int TICK_STEP     = 12500,
    parameter int SPEEDUP_EVERY = 40,
    parameter int JUMP_TICKS    = 3,
    parameter int MIN_GAP       = 5,
    parameter int SCORE_W       = 16
) (
    input  logic CLK,
    input  logic RST,
    runner_game_core_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam int AW = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;
    localparam logic [CW-1:0]      DIV_C  = CW'(TICK_DIV);
    localparam logic [CW-1:0]      MIN_C  = CW'(TICK_MIN);
    localparam logic [CW-1:0]      STEP_C = CW'((TICK_STEP > TICK_DIV) ? TICK_DIV : TICK_STEP);
    localparam logic [SCORE_W-1:0] SPD_C  = SCORE_W'(SPEEDUP_EVERY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t               state;
    logic                 jump_d, abort_d, jump_req;
    logic [2*COLS-1:0]    lane;
    logic                 air;
    logic [AW-1:0]        air_cnt;
    logic [SCORE_W-1:0]   score;
    logic                 tick;
    logic [CW-1:0]        period, cnt;

    logic                 jump_edge, abort_edge, tick_evt, gap_clear, collide;
    logic [2*COLS-1:0]    nxt_lane;
    logic                 nxt_air;
    logic [AW-1:0]        nxt_air_cnt;
    logic [SCORE_W-1:0]   nxt_score;
    logic [CW-1:0]        nxt_period;
    logic                 unused_rand;

    assign jump_edge   = bus.JUMP_KEY  & ~jump_d;
    assign abort_edge  = bus.ABORT_KEY & ~abort_d;
    assign tick_evt    = (cnt == period - 1'b1);
    assign unused_rand = ^bus.RAND[7:3];

    // Next frame, evaluated every cycle and committed only on a tick event.
    always_comb begin
        nxt_air     = air;
        nxt_air_cnt = air_cnt;
        if (!air && (jump_req || jump_edge)) begin
            nxt_air     = 1'b1;
            nxt_air_cnt = AW'(JUMP_TICKS - 1);
        end else if (air && air_cnt != '0) begin
            nxt_air_cnt = air_cnt - 1'b1;
        end else if (air) begin
            nxt_air = 1'b0;
        end

        // Shifted cells COLS-1-MIN_GAP..COLS-2 are the current cells COLS-MIN_GAP..COLS-1.
        gap_clear = 1'b1;
        for (int unsigned k = 0; k < COLS; k++) begin
            if ((k + MIN_GAP >= COLS) && (lane[2*k +: 2] != 2'd0))
                gap_clear = 1'b0;
        end

        nxt_lane = {2'b00, lane[2*COLS-1:2]};
        if (gap_clear && bus.RAND[1:0] != 2'd3)
            nxt_lane[2*COLS-1 -: 2] = bus.RAND[2] ? 2'd1 : 2'd2;

        collide   = (nxt_lane[1:0] != 2'd0) && !nxt_air;
        nxt_score = (score == '1) ? score : score + 1'b1;

        nxt_period = period;
        if ((nxt_score != '0) && (nxt_score % SPD_C == '0))
            nxt_period = (period - MIN_C >= STEP_C) ? period - STEP_C : MIN_C;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            jump_d   <= 1'b0;
            abort_d  <= 1'b0;
            jump_req <= 1'b0;
            lane     <= '0;
            air      <= 1'b0;
            air_cnt  <= '0;
            score    <= '0;
            tick     <= 1'b0;
            period   <= DIV_C;
            cnt      <= '0;
        end else begin
            jump_d  <= bus.JUMP_KEY;
            abort_d <= bus.ABORT_KEY;
            tick    <= 1'b0;
            if (!bus.ENABLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (jump_edge) begin
                            state    <= RUN;
                            lane     <= '0;
                            air      <= 1'b0;
                            air_cnt  <= '0;
                            score    <= '0;
                            jump_req <= 1'b0;
                            cnt      <= '0;
                            period   <= DIV_C;
                        end
                    end
                    RUN: begin
                        // Abort wins over a coincident tick; that tick's frame is dropped.
                        if (abort_edge) begin
                            state <= OVER;
                        end else if (tick_evt) begin
                            cnt      <= '0;
                            jump_req <= 1'b0;
                            lane     <= nxt_lane;
                            air      <= nxt_air;
                            air_cnt  <= nxt_air_cnt;
                            tick     <= 1'b1;
                            if (collide) begin
                                state <= OVER;
                            end else begin
                                score  <= nxt_score;
                                period <= nxt_period;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (jump_edge)
                                jump_req <= 1'b1;
                        end
                    end
                    OVER: begin
                        if (jump_edge || abort_edge)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RUNNER_HISCORE_EN
    logic [SCORE_W-1:0] hiscore;
    logic               game_end;

    // Final score is the unincremented one on both the collision and abort paths.
    assign game_end = bus.ENABLE && (state == RUN) && (abort_edge || (tick_evt && collide));

    always_ff @(posedge CLK) begin
        if (RST)
            hiscore <= '0;
        else if (game_end && score > hiscore)
            hiscore <= score;
    end

    assign bus.HISCORE = hiscore;
`else
    assign bus.HISCORE = '0;
`endif

    assign bus.STATE = state;
    assign bus.LANE  = lane;
    assign bus.AIR   = air;
    assign bus.SCORE = score;
    assign bus.TICK  = tick;
endmodule

// File: tb/tb_runner_game_core.sv
// Directed self-checking bench for runner_game_core with the small test-plan parameter set.
// Expected HISCORE follows RUNNER_HISCORE_EN as seen by this compilation.
module tb_runner_game_core;
    localparam int COLS = 8;

`ifdef RUNNER_HISCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    runner_game_core_if #(.COLS(COLS), .SCORE_W(16)) bus ();

    runner_game_core #(
        .COLS(COLS), .TICK_DIV(8), .TICK_MIN(4), .TICK_STEP(2),
        .SPEEDUP_EVERY(2), .JUMP_TICKS(2), .MIN_GAP(2), .SCORE_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next TICK (bounded) and checks the number of cycles it took.
    task automatic wait_tick(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.TICK !== 1'b1 && n < 40);
        chk({tag, "_gap"}, n, exp_n);
    endtask

    task automatic press_jump();
        bus.JUMP_KEY = 1'b1;
        @(negedge CLK);
        bus.JUMP_KEY = 1'b0;
    endtask

    task automatic press_abort();
        bus.ABORT_KEY = 1'b1;
        @(negedge CLK);
        bus.ABORT_KEY = 1'b0;
    endtask

    int          gaps  [7] = '{8, 8, 6, 6, 4, 4, 4};
    logic [15:0] lanes [7] = '{16'h4000, 16'h1000, 16'h0400, 16'h4100,
                               16'h1040, 16'h0410, 16'h4104};

    initial begin
        bus.ENABLE    = 1'b0;
        bus.JUMP_KEY  = 1'b0;
        bus.ABORT_KEY = 1'b0;
        bus.RAND      = 8'h04;
        repeat (3) @(negedge CLK);
        chk("rst_state", bus.STATE, 0);
        chk("rst_lane", bus.LANE, 0);
        chk("rst_air", bus.AIR, 0);
        chk("rst_score", bus.SCORE, 0);
        chk("rst_hiscore", bus.HISCORE, 0);
        chk("rst_tick", bus.TICK, 0);
        RST = 1'b0;

        // Key edge while disabled does not start a game.
        press_jump();
        chk("dis_idle", bus.STATE, 0);

        // Game A: no jump, collision on tick 8 with score 7.
        bus.ENABLE = 1'b1;
        @(negedge CLK);
        press_jump();
        chk("a_start_state", bus.STATE, 1);
        chk("a_start_lane", bus.LANE, 0);
        chk("a_start_score", bus.SCORE, 0);
        for (int i = 0; i < 7; i++) begin
            wait_tick($sformatf("a_t%0d", i + 1), gaps[i]);
            chk($sformatf("a_t%0d_score", i + 1), bus.SCORE, i + 1);
            chk($sformatf("a_t%0d_lane", i + 1), bus.LANE, lanes[i]);
            chk($sformatf("a_t%0d_state", i + 1), bus.STATE, 1);
        end
        wait_tick("a_t8", 4);
        chk("a_col_state", bus.STATE, 2);
        chk("a_col_score", bus.SCORE, 7);
        chk("a_col_lane", bus.LANE, 16'h1041);
        chk("a_col_air", bus.AIR, 0);
        chk("a_col_hiscore", bus.HISCORE, HS ? 32'd7 : 32'd0);
        @(negedge CLK);
        chk("a_over_tick", bus.TICK, 0);
        chk("a_over_frozen", bus.LANE, 16'h1041);

        press_jump();
        chk("a_idle_state", bus.STATE, 0);
        chk("a_idle_score", bus.SCORE, 7);
        chk("a_idle_lane", bus.LANE, 16'h1041);

        // Game C: abort edge on the same cycle as tick 4.
        @(negedge CLK);
        press_jump();
        chk("c_start_state", bus.STATE, 1);
        for (int i = 0; i < 3; i++)
            wait_tick($sformatf("c_t%0d", i + 1), gaps[i]);
        chk("c_t3_score", bus.SCORE, 3);
        repeat (5) @(negedge CLK);
        bus.ABORT_KEY = 1'b1;
        @(negedge CLK);
        chk("c_abort_state", bus.STATE, 2);
        chk("c_abort_tick", bus.TICK, 0);
        chk("c_abort_score", bus.SCORE, 3);
        chk("c_abort_lane", bus.LANE, 16'h0400);
        chk("c_abort_hiscore", bus.HISCORE, HS ? 32'd7 : 32'd0);
        bus.ABORT_KEY = 1'b0;
        @(negedge CLK);
        chk("c_held_over", bus.STATE, 2);
        press_abort();
        chk("c_idle_state", bus.STATE, 0);

        // Game B: jump over the first obstacle.
        @(negedge CLK);
        press_jump();
        chk("b_start_state", bus.STATE, 1);
        for (int i = 0; i < 7; i++)
            wait_tick($sformatf("b_t%0d", i + 1), gaps[i]);
        bus.JUMP_KEY = 1'b1;
        wait_tick("b_t8", 4);
        bus.JUMP_KEY = 1'b0;
        chk("b_t8_air", bus.AIR, 1);
        chk("b_t8_state", bus.STATE, 1);
        chk("b_t8_score", bus.SCORE, 8);
        chk("b_t8_lane", bus.LANE, 16'h1041);
        wait_tick("b_t9", 4);
        chk("b_t9_air", bus.AIR, 1);
        chk("b_t9_score", bus.SCORE, 9);
        chk("b_t9_lane", bus.LANE, 16'h0410);
        wait_tick("b_t10", 4);
        chk("b_t10_air", bus.AIR, 0);
        chk("b_t10_score", bus.SCORE, 10);
        chk("b_t10_lane", bus.LANE, 16'h4104);
        wait_tick("b_t11", 4);
        chk("b_col_state", bus.STATE, 2);
        chk("b_col_score", bus.SCORE, 10);
        chk("b_col_hiscore", bus.HISCORE, HS ? 32'd10 : 32'd0);

        // ENABLE low from OVER, then mid-game.
        bus.ENABLE = 1'b0;
        @(negedge CLK);
        chk("en_over_idle", bus.STATE, 0);
        bus.ENABLE = 1'b1;
        @(negedge CLK);
        press_jump();
        chk("d_start_state", bus.STATE, 1);
        wait_tick("d_t1", 8);
        bus.ENABLE = 1'b0;
        @(negedge CLK);
        chk("d_dis_state", bus.STATE, 0);
        chk("d_dis_tick", bus.TICK, 0);
        chk("d_dis_score", bus.SCORE, 1);
        chk("d_dis_lane", bus.LANE, 16'h4000);
        repeat (10) @(negedge CLK);
        chk("d_dis_still", bus.TICK, 0);

        // Mid-game reset clears everything, including the high score.
        bus.ENABLE = 1'b1;
        press_jump();
        chk("e_start_state", bus.STATE, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("e_rst_state", bus.STATE, 0);
        chk("e_rst_lane", bus.LANE, 0);
        chk("e_rst_score", bus.SCORE, 0);
        chk("e_rst_hiscore", bus.HISCORE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
